hazard_scoreboard: RTL and testbench

- Parametrised pipeline hazard unit for the multi-stage MIPS core.
- Tracks in-flight destination registers and when each result becomes available, per stage after decode.
- Compares them with the operands of the instruction in D and raises stall, forward-source indices and multiply/divide busy.
- Sits beside the decode controller, which supplies per-instruction register indices and the use/ready stage fields.

---
 rtl/hazard_pkg.sv | 32 +++
 rtl/md_busy_counter.sv | 28 ++
 rtl/hazard_scoreboard.sv | 110 +++++++++++
 tb/tb_hazard_scoreboard.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared constants, scoreboard entry type and match helper
// for the pipeline hazard unit and the decode controller.
package hazard_pkg;

  localparam int SB_AW = 5;
  localparam int SB_SW = 2;

  localparam logic [SB_SW-1:0] STAGE_D = 2'd0;
  localparam logic [SB_SW-1:0] STAGE_E = 2'd1;
  localparam logic [SB_SW-1:0] STAGE_M = 2'd2;
  localparam logic [SB_SW-1:0] STAGE_W = 2'd3;

  localparam logic [SB_SW-1:0] READY_ALU = 2'd1;
  localparam logic [SB_SW-1:0] READY_MEM = 2'd2;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] dst;
    logic [SB_SW-1:0] ready;
  } sb_entry_t;

  // $0 is hardwired, so it never forms a dependency
  function automatic logic sb_match(
    input sb_entry_t        e,
    input logic [SB_AW-1:0] src,
    input logic             req
  );
    return req && (src != '0) &&
           e.valid && (e.dst == src);
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Multiply/divide busy timer: loads on an accepted start,
// then counts down to zero.
module md_busy_counter #(
  parameter int MD_LATENCY = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  localparam int CW = $clog2(MD_LATENCY + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MD_LATENCY);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: stall, forward-source and MD busy.
// HAZARD_FORWARD_EN enables bypass-aware hazards and fwd outputs.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int REG_AW     = 5,
  parameter int STG_W      = 2,
  parameter int MD_LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_src1,
  input  logic [STG_W-1:0]  dec_src1_use,
  input  logic              dec_src1_req,
  input  logic [REG_AW-1:0] dec_src2,
  input  logic [STG_W-1:0]  dec_src2_use,
  input  logic              dec_src2_req,
  input  logic [REG_AW-1:0] dec_dst,
  input  logic [STG_W-1:0]  dec_dst_ready,
  input  logic              dec_md_start,
  input  logic              dec_md_use,
  output logic              stall,
  output logic [STG_W-1:0]  fwd1_stage,
  output logic [STG_W-1:0]  fwd2_stage,
  output logic              md_busy
);

  localparam int NE = NUM_STAGES - 1;

  sb_entry_t        sb [1:NE];
  sb_entry_t        d_ent;
  logic             m1, m2;
  logic [STG_W-1:0] k1, k2, r1, r2;
  logic             haz1, haz2, md_haz;
  logic             accept;

  // scan oldest to youngest so the lowest k wins
  always_comb begin
    m1 = 1'b0;
    k1 = '0;
    r1 = '0;
    m2 = 1'b0;
    k2 = '0;
    r2 = '0;
    for (int k = NE; k >= 1; k--) begin
      if (sb_match(sb[k], dec_src1, dec_src1_req)) begin
        m1 = 1'b1;
        k1 = STG_W'(k);
        r1 = sb[k].ready;
      end
      if (sb_match(sb[k], dec_src2, dec_src2_req)) begin
        m2 = 1'b1;
        k2 = STG_W'(k);
        r2 = sb[k].ready;
      end
    end
  end

`ifdef HAZARD_FORWARD_EN
  assign haz1 = m1 &&
    (({1'b0, k1} + {1'b0, dec_src1_use}) <= {1'b0, r1});
  assign haz2 = m2 &&
    (({1'b0, k2} + {1'b0, dec_src2_use}) <= {1'b0, r2});
  assign fwd1_stage = k1;
  assign fwd2_stage = k2;
`else
  assign haz1 = m1 && (k1 <= STG_W'(NUM_STAGES - 2));
  assign haz2 = m2 && (k2 <= STG_W'(NUM_STAGES - 2));
  assign fwd1_stage = '0;
  assign fwd2_stage = '0;

  logic unused_fwd;
  assign unused_fwd = ^{dec_src1_use, dec_src2_use, r1, r2};
`endif

  assign md_haz = (dec_md_use | dec_md_start) & md_busy;
  assign stall  = dec_valid & ~flush &
                  (haz1 | haz2 | md_haz);
  assign accept = dec_valid & ~flush & ~stall;

  md_busy_counter #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md (
    .clk   (clk),
    .reset (reset),
    .load  (accept & dec_md_start),
    .busy  (md_busy)
  );

  assign d_ent = '{valid: 1'b1,
                   dst:   dec_dst,
                   ready: dec_dst_ready};

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 1; k <= NE; k++) begin
        sb[k] <= '0;
      end
    end else begin
      sb[1] <= (accept && (dec_dst != '0)) ? d_ent : '0;
      for (int k = 2; k <= NE; k++) begin
        sb[k] <= sb[k-1];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard; expectations
// follow HAZARD_FORWARD_EN when the macro is defined.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    bit         vld;
    bit         fl;
    bit         rst;
    logic [4:0] s1;
    logic [1:0] u1;
    bit         q1;
    logic [4:0] s2;
    logic [1:0] u2;
    bit         q2;
    logic [4:0] dst;
    logic [1:0] rdy;
    bit         mds;
    bit         mdu;
    bit         e_st;
    logic [1:0] e_f1;
    logic [1:0] e_f2;
    bit         e_bz;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic       dec_valid;
  logic [4:0] dec_src1;
  logic [1:0] dec_src1_use;
  logic       dec_src1_req;
  logic [4:0] dec_src2;
  logic [1:0] dec_src2_use;
  logic       dec_src2_req;
  logic [4:0] dec_dst;
  logic [1:0] dec_dst_ready;
  logic       dec_md_start;
  logic       dec_md_use;
  logic       stall;
  logic [1:0] fwd1_stage;
  logic [1:0] fwd2_stage;
  logic       md_busy;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t tbl [$];
  vec_t exp_q [$];

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_STAGES (4),
    .REG_AW     (5),
    .STG_W      (2),
    .MD_LATENCY (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .dec_valid     (dec_valid),
    .dec_src1      (dec_src1),
    .dec_src1_use  (dec_src1_use),
    .dec_src1_req  (dec_src1_req),
    .dec_src2      (dec_src2),
    .dec_src2_use  (dec_src2_use),
    .dec_src2_req  (dec_src2_req),
    .dec_dst       (dec_dst),
    .dec_dst_ready (dec_dst_ready),
    .dec_md_start  (dec_md_start),
    .dec_md_use    (dec_md_use),
    .stall         (stall),
    .fwd1_stage    (fwd1_stage),
    .fwd2_stage    (fwd2_stage),
    .md_busy       (md_busy)
  );

  function automatic vec_t nop();
    vec_t v = '0;
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t ins();
    vec_t v = nop();
    v.vld = 1'b1;
    return v;
  endfunction

  function automatic vec_t alu(int d, int a, int b);
    vec_t v = ins();
    v.dst = 5'(d);
    v.rdy = READY_ALU;
    v.s1  = 5'(a);
    v.u1  = STAGE_E;
    v.q1  = (a != 0);
    v.s2  = 5'(b);
    v.u2  = STAGE_E;
    v.q2  = (b != 0);
    return v;
  endfunction

  function automatic vec_t lw(int d, int a);
    vec_t v = alu(d, a, 0);
    v.rdy = READY_MEM;
    return v;
  endfunction

  function automatic vec_t beq(int a, int b);
    vec_t v = alu(0, a, b);
    v.u1 = STAGE_D;
    v.u2 = STAGE_D;
    return v;
  endfunction

  function automatic vec_t mult(int a, int b);
    vec_t v = alu(0, a, b);
    v.mds = 1'b1;
    return v;
  endfunction

  function automatic vec_t mflo(int d);
    vec_t v = alu(d, 0, 0);
    v.mdu = 1'b1;
    return v;
  endfunction

  function automatic vec_t fl(vec_t v);
    vec_t r = v;
    r.fl = 1'b1;
    return r;
  endfunction

  function automatic vec_t rs(vec_t v);
    vec_t r = v;
    r.rst = 1'b0;
    return r;
  endfunction

  function automatic vec_t inv(vec_t v);
    vec_t r = v;
    r.vld = 1'b0;
    return r;
  endfunction

  function automatic vec_t ex(
    vec_t v, int st, int f1, int f2, int bz
  );
    vec_t r = v;
    r.e_st = (st != 0);
    r.e_f1 = 2'(f1);
    r.e_f2 = 2'(f2);
    r.e_bz = (bz != 0);
    return r;
  endfunction

  task automatic add(vec_t v);
    tbl.push_back(v);
  endtask

  task automatic drain(int bz);
    for (int i = 0; i < 3; i++) add(ex(nop(), 0, 0, 0, bz));
  endtask

  task automatic drive(vec_t v);
    reset         = v.rst;
    flush         = v.fl;
    dec_valid     = v.vld;
    dec_src1      = v.s1;
    dec_src1_use  = v.u1;
    dec_src1_req  = v.q1;
    dec_src2      = v.s2;
    dec_src2_use  = v.u2;
    dec_src2_req  = v.q2;
    dec_dst       = v.dst;
    dec_dst_ready = v.rdy;
    dec_md_start  = v.mds;
    dec_md_use    = v.mdu;
  endtask

  task automatic cmp(string nm, int row, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL row%0d %s got %0d want %0d",
               row, nm, got, want);
    end
  endtask

  task automatic check(int row);
    vec_t e = exp_q.pop_front();
    cmp("stall", row, int'(stall), int'(e.e_st));
    cmp("fwd1", row, int'(fwd1_stage), int'(e.e_f1));
    cmp("fwd2", row, int'(fwd2_stage), int'(e.e_f2));
    cmp("md_busy", row, int'(md_busy), int'(e.e_bz));
  endtask

  initial begin
    vec_t z;

    add(ex(nop(), 0, 0, 0, 0));
`ifdef HAZARD_FORWARD_EN
    add(ex(alu(3, 1, 2), 0, 0, 0, 0));
    add(ex(alu(6, 3, 0), 0, 1, 0, 0));
    add(ex(alu(7, 3, 6), 0, 2, 1, 0));
    add(ex(alu(8, 3, 3), 0, 3, 3, 0));
    drain(0);
    add(ex(lw(5, 0), 0, 0, 0, 0));
    add(ex(alu(9, 5, 0), 1, 1, 0, 0));
    add(ex(alu(9, 5, 0), 0, 2, 0, 0));
    drain(0);
    add(ex(alu(4, 1, 0), 0, 0, 0, 0));
    add(ex(beq(4, 0), 1, 1, 0, 0));
    add(ex(beq(4, 0), 0, 2, 0, 0));
    drain(0);
    add(ex(lw(4, 1), 0, 0, 0, 0));
    add(ex(beq(4, 0), 1, 1, 0, 0));
    add(ex(beq(4, 0), 1, 2, 0, 0));
    add(ex(beq(4, 0), 0, 3, 0, 0));
    drain(0);
    add(ex(lw(5, 0), 0, 0, 0, 0));
    add(ex(inv(alu(9, 5, 0)), 0, 1, 0, 0));
`else
    add(ex(alu(3, 1, 2), 0, 0, 0, 0));
    add(ex(alu(6, 3, 0), 1, 0, 0, 0));
    add(ex(alu(6, 3, 0), 1, 0, 0, 0));
    add(ex(alu(6, 3, 0), 0, 0, 0, 0));
    drain(0);
    add(ex(lw(5, 0), 0, 0, 0, 0));
    add(ex(alu(9, 5, 0), 1, 0, 0, 0));
    add(ex(alu(9, 5, 0), 1, 0, 0, 0));
    add(ex(alu(9, 5, 0), 0, 0, 0, 0));
    drain(0);
    add(ex(alu(4, 1, 0), 0, 0, 0, 0));
    add(ex(beq(4, 0), 1, 0, 0, 0));
    add(ex(beq(4, 0), 1, 0, 0, 0));
    add(ex(beq(4, 0), 0, 0, 0, 0));
    drain(0);
    add(ex(lw(4, 1), 0, 0, 0, 0));
    add(ex(beq(4, 0), 1, 0, 0, 0));
    add(ex(beq(4, 0), 1, 0, 0, 0));
    add(ex(beq(4, 0), 0, 0, 0, 0));
    drain(0);
    add(ex(lw(5, 0), 0, 0, 0, 0));
    add(ex(inv(alu(9, 5, 0)), 0, 0, 0, 0));
`endif
    drain(0);
    add(ex(alu(0, 1, 2), 0, 0, 0, 0));
    z = beq(0, 0);
    z.q1 = 1'b1;
    add(ex(z, 0, 0, 0, 0));
    add(ex(alu(11, 11, 0), 0, 0, 0, 0));
    add(ex(alu(12, 11, 0), FWD ? 0 : 1, FWD ? 1 : 0, 0, 0));
    drain(0);
    add(ex(lw(5, 0), 0, 0, 0, 0));
    add(ex(fl(alu(9, 5, 0)), 0, FWD ? 1 : 0, 0, 0));
`ifdef HAZARD_FORWARD_EN
    add(ex(alu(15, 9, 5), 0, 0, 2, 0));
`else
    add(ex(alu(15, 9, 5), 1, 0, 0, 0));
    add(ex(alu(15, 9, 5), 0, 0, 0, 0));
`endif
    drain(0);
    add(ex(mult(1, 2), 0, 0, 0, 0));
    add(ex(alu(13, 1, 0), 0, 0, 0, 1));
    for (int i = 0; i < 4; i++) add(ex(mflo(14), 1, 0, 0, 1));
    add(ex(mflo(14), 0, 0, 0, 0));
    add(ex(nop(), 0, 0, 0, 0));
    add(ex(mult(1, 2), 0, 0, 0, 0));
    add(ex(mult(3, 4), 1, 0, 0, 1));
    add(ex(fl(mult(3, 4)), 0, 0, 0, 1));
    drain(1);
    add(ex(nop(), 0, 0, 0, 0));
    drain(0);
    add(ex(mult(1, 2), 0, 0, 0, 0));
    add(ex(lw(5, 0), 0, 0, 0, 1));
    add(ex(rs(alu(9, 5, 0)), 1, FWD ? 1 : 0, 0, 1));
    add(ex(alu(9, 5, 0), 0, 0, 0, 0));

    drive(rs(nop()));
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      #1;
      check(i);
    end

    @(negedge clk);
    drive(nop());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
